// File: rtl/texture_stream_source.sv
// Texture upload source: fetches a square texture over the memory read port and streams it out
// as AXI-Stream with tlast on the final beat. Macro TEXTURE_STREAM_BYTE_SWAP_EN byte-swaps each pixel.
module texture_stream_source #(
  parameter int unsigned STREAM_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [3:0]              mode,
  input  logic                    cmdValid,
  output logic                    cmdReady,
  input  logic [ADDR_WIDTH-1:0]   cmdAddr,
  output logic                    busy,
  output logic                    err,
  output logic                    m_rd_req,
  input  logic                    m_rd_ack,
  output logic [ADDR_WIDTH-1:0]   m_rd_addr,
  input  logic                    m_rd_data_valid,
  input  logic [STREAM_WIDTH-1:0] m_rd_data,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [STREAM_WIDTH-1:0] m_axis_tdata
);

  localparam int unsigned CNT_W      = 15;
  localparam int unsigned FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PTR_W      = FIFO_DEPTH_LOG2;
  localparam int unsigned OCC_W      = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned LANE_SHIFT = $clog2(STREAM_WIDTH / 16);
  localparam int unsigned BYTES      = STREAM_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        beat_total;
  logic [CNT_W-1:0]        req_cnt;
  logic [CNT_W-1:0]        load_cnt;
  logic [CNT_W-1:0]        inflight;
  logic [CNT_W-1:0]        inflight_nxt;
  logic [STREAM_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [OCC_W-1:0]        fifo_occ;
  logic [STREAM_WIDTH-1:0] wr_data;
  logic [CNT_W-1:0]        mode_beats;
  logic                    mode_legal;
  logic                    ack_fire;
  logic                    pop_fire;
  logic                    out_free;
  logic                    push;
  logic                    load_mem;
  logic                    load_byp;
  logic                    store;

  // Beat count per legal mode; pixels shrink by the number of 16-bit lanes per beat
  always_comb begin
    mode_legal = 1'b1;
    mode_beats = '0;
    case (mode)
      4'b0001: mode_beats = CNT_W'(1024 >> LANE_SHIFT);
      4'b0010: mode_beats = CNT_W'(4096 >> LANE_SHIFT);
      4'b0100: mode_beats = CNT_W'(16384 >> LANE_SHIFT);
      default: mode_legal = 1'b0;
    endcase
  end

`ifdef TEXTURE_STREAM_BYTE_SWAP_EN
  // Big-endian texture memory: swap bytes inside every pixel lane
  always_comb begin
    wr_data = '0;
    for (int i = 0; i < int'(STREAM_WIDTH / 16); i++)
      wr_data[16*i +: 16] = {m_rd_data[16*i +: 8], m_rd_data[16*i+8 +: 8]};
  end
`else
  assign wr_data = m_rd_data;
`endif

  // Handshakes; an empty store lets returning data bypass straight into the output register
  always_comb begin
    ack_fire     = m_rd_req && m_rd_ack;
    pop_fire     = m_axis_tvalid && m_axis_tready;
    out_free     = !m_axis_tvalid || m_axis_tready;
    push         = m_rd_data_valid && (state != IDLE);
    load_mem     = out_free && (fifo_occ != '0);
    load_byp     = out_free && (fifo_occ == '0) && push;
    store        = push && !load_byp;
    inflight_nxt = inflight + CNT_W'(ack_fire) - CNT_W'(pop_fire);
  end

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      cmdReady      <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
      m_rd_req      <= 1'b0;
      m_rd_addr     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      beat_total    <= '0;
      req_cnt       <= '0;
      load_cnt      <= '0;
      inflight      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_occ      <= '0;
    end else begin
      err      <= 1'b0;
      inflight <= inflight_nxt;
      fifo_occ <= fifo_occ + OCC_W'(store) - OCC_W'(load_mem);
      if (store)    wr_ptr <= wr_ptr + PTR_W'(1);
      if (load_mem) rd_ptr <= rd_ptr + PTR_W'(1);

      // Output register reloads only when empty or being consumed, so stalls hold data/tlast
      if (load_mem || load_byp) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= load_mem ? mem[rd_ptr] : wr_data;
        m_axis_tlast  <= (load_cnt == beat_total - CNT_W'(1));
        load_cnt      <= load_cnt + CNT_W'(1);
      end else if (pop_fire) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end

      case (state)
        IDLE: begin
          cmdReady <= 1'b1;
          if (cmdReady && cmdValid) begin
            if (mode_legal) begin
              cmdReady   <= 1'b0;
              busy       <= 1'b1;
              m_rd_req   <= 1'b1;
              m_rd_addr  <= cmdAddr;
              beat_total <= mode_beats;
              req_cnt    <= '0;
              load_cnt   <= '0;
              inflight   <= '0;
              state      <= ISSUE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (ack_fire) begin
            m_rd_addr <= m_rd_addr + ADDR_WIDTH'(BYTES);
            req_cnt   <= req_cnt + CNT_W'(1);
          end
          if (ack_fire && (req_cnt == beat_total - CNT_W'(1))) begin
            m_rd_req <= 1'b0;
            state    <= DRAIN;
          end else begin
            m_rd_req <= (inflight_nxt < CNT_W'(FIFO_DEPTH));
          end
        end
        DRAIN: begin
          if (pop_fire && m_axis_tlast) begin
            busy     <= 1'b0;
            cmdReady <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_texture_stream_source.sv
// Directed bench for texture_stream_source: a 16-bit instance with a latency-modelled memory
// and a 64-bit instance running one 128x128 upload in parallel.
module tb_texture_stream_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        resetn, cmd_valid, cmd_ready, busy, err;
  logic [3:0]  mode;
  logic [31:0] cmd_addr, rd_addr;
  logic        rd_req, rd_ack, rd_dv, tvalid, tready, tlast;
  logic [15:0] rd_data, tdata;

  // 64-bit instance
  logic        resetn64, cmd_valid64, cmd_ready64, busy64, err64;
  logic [3:0]  mode64;
  logic [31:0] cmd_addr64, rd_addr64;
  logic        rd_req64, rd_ack64, rd_dv64, tvalid64, tready64, tlast64;
  logic [63:0] rd_data64, tdata64;

  texture_stream_source #(.STREAM_WIDTH(16), .ADDR_WIDTH(32), .FIFO_DEPTH_LOG2(2)) u_dut (
    .clk(clk), .resetn(resetn), .mode(mode), .cmdValid(cmd_valid), .cmdReady(cmd_ready),
    .cmdAddr(cmd_addr), .busy(busy), .err(err), .m_rd_req(rd_req), .m_rd_ack(rd_ack),
    .m_rd_addr(rd_addr), .m_rd_data_valid(rd_dv), .m_rd_data(rd_data),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast), .m_axis_tdata(tdata));

  texture_stream_source #(.STREAM_WIDTH(64), .ADDR_WIDTH(32), .FIFO_DEPTH_LOG2(2)) u_dut64 (
    .clk(clk), .resetn(resetn64), .mode(mode64), .cmdValid(cmd_valid64), .cmdReady(cmd_ready64),
    .cmdAddr(cmd_addr64), .busy(busy64), .err(err64), .m_rd_req(rd_req64), .m_rd_ack(rd_ack64),
    .m_rd_addr(rd_addr64), .m_rd_data_valid(rd_dv64), .m_rd_data(rd_data64),
    .m_axis_tvalid(tvalid64), .m_axis_tready(tready64), .m_axis_tlast(tlast64), .m_axis_tdata(tdata64));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected pixel for a memory that returns the low 16 address bits
  function automatic logic [15:0] pix(input logic [31:0] a);
`ifdef TEXTURE_STREAM_BYTE_SWAP_EN
    return {a[7:0], a[15:8]};
`else
    return a[15:0];
`endif
  endfunction

  // 16-bit side bench state
  int          cyc = 0, rx = 0, acked = 0, max_out = 0, exp_beats = 0, last_due = 0;
  logic [31:0] exp_base = 0, last_ack_addr = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];
  bit          rnd = 0, spur = 0, done_flag = 0;
  bit          prev_stall = 0, prev_last = 0, prev_req_wait = 0;
  logic [15:0] prev_data = 0, first_data = 0, last_data = 0, d282 = 0;
  logic [31:0] prev_addr = 0;
  bit          saw_tvalid = 0, saw_req = 0, saw_tlast = 0;
  bit          fin64 = 0;

  // One cycle: observe at the falling edge, then drive inputs for the next rising edge
  task automatic step();
    int lat;
    int due;
    @(negedge clk);
    cyc++;
    if (tvalid) saw_tvalid = 1;
    if (rd_req) saw_req = 1;
    if (tvalid && tlast) saw_tlast = 1;
    if (prev_stall) begin
      check("stall_tdata", tdata, prev_data);
      check("stall_tlast", tlast, prev_last);
    end
    if (prev_req_wait) begin
      check("req_hold", rd_req, 1);
      check("addr_hold", rd_addr, prev_addr);
    end
    rd_dv = 0;
    rd_data = 16'h0;
    if (q_due.size() > 0 && q_due[0] == cyc) begin
      rd_dv = 1;
      rd_data = q_addr[0][15:0];
      void'(q_due.pop_front());
      void'(q_addr.pop_front());
    end
    if (spur) begin
      rd_dv = 1;
      rd_data = 16'hBEEF;
    end
    rd_ack = rnd ? ($urandom_range(3) != 0) : 1'b1;
    tready = rnd ? 1'($urandom_range(1)) : 1'b1;
    if (rd_req && rd_ack) begin
      lat = rnd ? int'($urandom_range(6, 1)) : 1;
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      q_addr.push_back(rd_addr);
      q_due.push_back(due);
      acked++;
      last_ack_addr = rd_addr;
      if (acked - rx > max_out) max_out = acked - rx;
    end
    if (tvalid && tready) begin
      check("tdata", tdata, pix(exp_base + 32'(2 * rx)));
      check("tlast", tlast, rx == exp_beats - 1);
      if (rx == 0) first_data = tdata;
      if (rx == 282) d282 = tdata;
      if (rx == exp_beats - 1) last_data = tdata;
      if (tlast) done_flag = 1;
      rx++;
    end
    prev_stall    = tvalid && !tready;
    prev_data     = tdata;
    prev_last     = tlast;
    prev_req_wait = rd_req && !rd_ack;
    prev_addr     = rd_addr;
  endtask

  task automatic start_cmd(input logic [3:0] m, input logic [31:0] a, input int beats);
    check("cmd_ready_before", cmd_ready, 1);
    exp_base = a; exp_beats = beats;
    rx = 0; acked = 0; max_out = 0; done_flag = 0;
    mode = m; cmd_addr = a; cmd_valid = 1;
    step();
    cmd_valid = 0;
    check("busy_on_accept", busy, 1);
    check("req_after_accept", rd_req, 1);
  endtask

  task automatic run_cmd(input logic [3:0] m, input logic [31:0] a, input int beats);
    int n;
    start_cmd(m, a, beats);
    n = 0;
    while (!done_flag && n < 20000) begin
      step();
      n++;
    end
    check("done_in_time", done_flag, 1);
    step();
    check("busy_after", busy, 0);
    check("ready_after", cmd_ready, 1);
    check("tvalid_after", tvalid, 0);
    check("tlast_after", tlast, 0);
    check("beats", rx, beats);
    check("reqs", acked, beats);
    check("outstanding_le4", max_out <= 4, 1);
  endtask

  initial begin
    logic [3:0] bad_modes [2];
    int n;
    resetn = 0; cmd_valid = 0; mode = 0; cmd_addr = 0;
    rd_ack = 0; rd_dv = 0; rd_data = 0; tready = 0;
    repeat (3) step();
    check("rst_cmdReady", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_req", rd_req, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tdata", tdata, 0);
    resetn = 1;
    step(); step();
    check("idle_ready", cmd_ready, 1);

    // Read data arriving while idle must not reach the stream
    spur = 1; step(); spur = 0;
    step();
    check("idle_dv_ignored", tvalid, 0);

    // 32x32 at 0x1000, latency 1, always ready
    run_cmd(4'b0001, 32'h1000, 1024);
    check("last_req_addr", last_ack_addr, 32'h17FE);
`ifdef TEXTURE_STREAM_BYTE_SWAP_EN
    check("first_pix", first_data, 16'h0010);
    check("pix_1234", d282, 16'h3412);
    check("last_pix", last_data, 16'hFE17);
`else
    check("first_pix", first_data, 16'h1000);
    check("pix_1234", d282, 16'h1234);
    check("last_pix", last_data, 16'h17FE);
`endif

    // Random ready, ack and latency 1..6
    rnd = 1;
    run_cmd(4'b0001, 32'h4000, 1024);
    rnd = 0;

    // Illegal modes: err pulse only
    bad_modes[0] = 4'b1000;
    bad_modes[1] = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      check("ill_ready_before", cmd_ready, 1);
      mode = bad_modes[k]; cmd_addr = 32'h100; cmd_valid = 1;
      saw_req = 0; saw_tvalid = 0;
      step();
      cmd_valid = 0;
      check("ill_err", err, 1);
      check("ill_busy", busy, 0);
      check("ill_ready", cmd_ready, 1);
      step();
      check("ill_err_pulse", err, 0);
      repeat (8) step();
      check("ill_no_req", saw_req, 0);
      check("ill_no_tvalid", saw_tvalid, 0);
    end

    // Reset at beat 100 of a 64x64 upload
    start_cmd(4'b0010, 32'h8000, 4096);
    n = 0;
    while (rx < 100 && n < 5000) begin
      step();
      n++;
    end
    check("reached_beat100", rx >= 100, 1);
    resetn = 0;
    step();
    check("abort_cmdReady", cmd_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_err", err, 0);
    check("abort_req", rd_req, 0);
    check("abort_addr", rd_addr, 0);
    check("abort_tvalid", tvalid, 0);
    check("abort_tlast", tlast, 0);
    check("abort_tdata", tdata, 0);
    resetn = 1;
    saw_tlast = 0; saw_tvalid = 0; saw_req = 0;
    repeat (10) step();
    check("abort_no_tlast", saw_tlast, 0);
    check("abort_no_tvalid", saw_tvalid, 0);
    check("abort_no_req", saw_req, 0);
    run_cmd(4'b0001, 32'h0, 1024);
    check("post_abort_last_addr", last_ack_addr, 32'h07FE);

    n = 0;
    while (!fin64 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("dut64_finished", fin64, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // 64-bit instance: 128x128 at 0x2000, latency 1, always ready
  initial begin
    int          rx64, acked64, n;
    bit          pend, done64;
    logic [31:0] pend_addr, last64, a;
    rx64 = 0; acked64 = 0; pend = 0; done64 = 0; pend_addr = 0; last64 = 0;
    resetn64 = 0; cmd_valid64 = 0; mode64 = 0; cmd_addr64 = 0;
    rd_ack64 = 1; rd_dv64 = 0; rd_data64 = 0; tready64 = 1;
    repeat (3) @(negedge clk);
    resetn64 = 1;
    repeat (2) @(negedge clk);
    check("w64_ready", cmd_ready64, 1);
    mode64 = 4'b0100; cmd_addr64 = 32'h2000; cmd_valid64 = 1;
    n = 0;
    while (!done64 && n < 20000) begin
      @(negedge clk);
      cmd_valid64 = 0;
      rd_dv64 = pend;
      rd_data64 = {16'(pend_addr + 6), 16'(pend_addr + 4), 16'(pend_addr + 2), pend_addr[15:0]};
      pend = rd_req64;
      if (rd_req64) begin
        pend_addr = rd_addr64;
        last64 = rd_addr64;
        acked64++;
      end
      if (tvalid64) begin
        a = 32'h2000 + 32'(8 * rx64);
        check("w64_tdata", tdata64, {pix(a + 6), pix(a + 4), pix(a + 2), pix(a)});
        check("w64_tlast", tlast64, rx64 == 4095);
        if (tlast64) done64 = 1;
        rx64++;
      end
      n++;
    end
    check("w64_done", done64, 1);
    check("w64_beats", rx64, 4096);
    check("w64_reqs", acked64, 4096);
    check("w64_last_addr", last64, 32'h9FF8);
    @(negedge clk);
    check("w64_busy_after", busy64, 0);
    check("w64_err", err64, 0);
    fin64 = 1;
  end

endmodule

// File: doc/texture_stream_source.md
Name: texture_stream_source

Overview:
- Transmitter side of the texture AXI-Stream link: reads a square texture from external memory and emits it as an AXI-Stream whose final beat carries tlast, in the stream format the texture buffer consumes.
- Sits between the memory read port and the texture buffer write stream. The host issues one command per texture upload (base address plus texture mode).

Parameters:
- STREAM_WIDTH, 16, data width in bits of memory read data and of the output stream; one of 16, 32, 64.
- ADDR_WIDTH, 32, byte-address width of the memory read port.
- FIFO_DEPTH_LOG2, 2, log2 of the output FIFO depth, which is also the maximum number of outstanding read requests.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- mode  in  4  texture size; sampled on command accept. 4'b0001 = 32x32, 4'b0010 = 64x64, 4'b0100 = 128x128; all other codes are illegal.
- cmdValid  in  1  command request.
- cmdReady  out  1  command accepted when cmdValid and cmdReady are both high.
- cmdAddr  in  ADDR_WIDTH  texture base byte address; must be aligned to STREAM_WIDTH/8.
- busy  out  1  high from command accept until the tlast beat is transferred.
- err  out  1  one-cycle pulse when a command with an illegal mode is accepted.
- m_rd_req  out  1  read request valid.
- m_rd_ack  in  1  read request accepted when m_rd_req and m_rd_ack are both high.
- m_rd_addr  out  ADDR_WIDTH  read byte address.
- m_rd_data_valid  in  1  read data return, in request order, any latency ≥1.
- m_rd_data  in  STREAM_WIDTH  returned read data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  high on the final beat of the texture.
- m_axis_tdata  out  STREAM_WIDTH  stream data; 16-bit pixels packed with the lowest pixel index in the LSBs.

Behaviour:
- Reset values: cmdReady=0, busy=0, err=0, m_rd_req=0, m_rd_addr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
- Reset clears the FSM, counters and FIFO. Reset mid-transfer aborts the transfer: no tlast is emitted and no further requests are issued.
- Total beats: BEATS = pixels*16/STREAM_WIDTH, where pixels = 1024, 4096 or 16384 for the three legal modes.
  - STREAM_WIDTH=16 gives 1024 / 4096 / 16384 beats.
  - STREAM_WIDTH=64 gives 256 / 1024 / 4096 beats.
- Counters: request counter, beat counter and credit counter are all sized for 16384 beats.
- FSM states:
  - IDLE: cmdReady=1.
    - On accept with a legal mode: latch address and BEATS, busy<=1, go to ISSUE.
    - On accept with an illegal mode: err pulses the next cycle, busy stays 0, stay in IDLE.
  - ISSUE: m_rd_req asserted starting the cycle after accept. It stays high while credits are available.
    - credits = 2^FIFO_DEPTH_LOG2 − (requests issued − beats popped from the FIFO).
    - Each ack advances m_rd_addr by STREAM_WIDTH/8.
    - m_rd_addr and m_rd_req are held stable while m_rd_ack=0.
    - After the ack of request BEATS−1: m_rd_req<=0 next cycle, go to DRAIN.
  - DRAIN: waits until the tlast beat is transferred, then busy<=0, m_axis_tlast<=0, return to IDLE. cmdReady rises in the same cycle.
- FIFO:
  - Written on m_rd_data_valid; the credit scheme guarantees it never overflows.
  - Registered output: m_axis_tvalid goes high at the earliest one cycle after the first m_rd_data_valid.
  - Output data and tlast are held stable while m_axis_tvalid=1 and m_axis_tready=0.
- tlast: asserted exactly on beat BEATS−1 and on no other beat.
- Simultaneous FIFO push and pop in one cycle is supported, including when the FIFO is full.
- m_rd_data_valid while in IDLE is ignored and not written to the FIFO.

Optional Feature:
- Macro TEXTURE_STREAM_BYTE_SWAP_EN.
- Defined: every 16-bit pixel in m_rd_data is byte-swapped before entering the FIFO, i.e. {d[7:0], d[15:8]} per pixel lane, for big-endian texture memory.
- Undefined: data passes through unmodified.
- Latency and handshake behaviour are identical in both builds.

Test Plan:
- STREAM_WIDTH=16, mode=4'b0001, cmdAddr=0x1000, memory returning addr[15:0] with latency 1, tready=1 -> 1024 beats, tdata sequence 0x1000,0x1002,… ends 0x17FE, tlast only on beat 1023, busy low the cycle after.
- STREAM_WIDTH=64, mode=4'b0100 -> exactly 4096 beats, last m_rd_addr = base+0x7FF8.
- Random tready (50%) and latency 1–6 with FIFO_DEPTH_LOG2=2 -> never more than 4 outstanding reads, no FIFO overflow, data order preserved, tdata/tlast stable during stalls.
- mode=4'b1000 accepted -> err pulses 1 cycle, no m_rd_req, no tvalid, cmdReady stays 1.
- resetn low for 1 cycle at beat 100 of a 64x64 transfer -> all outputs at reset values the next cycle, no tlast, a new command is accepted and completes correctly.
- TEXTURE_STREAM_BYTE_SWAP_EN defined, memory data 0x1234 -> tdata 0x3412; undefined -> 0x1234.
